// File: rtl/alu16_sequencer.sv
// Sequences a 16-bit operation through an external 4-bit ALU slice, one nibble per cycle,
// chaining carry/borrow between nibbles and assembling the result and 16-bit flags.
module alu16_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] s,
  input  logic [15:0] r,
  input  logic        cin,
  output logic [3:0]  alu_R,
  output logic [3:0]  alu_S,
  output logic        alu_CI,
  output logic [1:0]  alu_I,
  input  logic [3:0]  alu_F,
  input  logic        alu_CO,
  input  logic        alu_VO,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        co,
  output logic        vo,
  output logic        no,
  output logic        zo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q;
  logic [1:0]  op_q;
  logic [15:0] s_q;
  logic [15:0] r_q;
  logic        cin_q;
  logic        carry_q;
  logic [11:0] acc_q;
  logic [15:0] result_q;
  logic        co_q, vo_q, no_q, zo_q;
  logic [15:0] final_w;

  function automatic logic [3:0] nibble(input logic [15:0] w, input logic [1:0] idx);
    return w[{idx, 2'b00} +: 4];
  endfunction

  // Subtract: the slice reports a borrow on CO, so the next nibble needs its inverse.
  function automatic logic chain_ci(input logic [1:0] opc, input logic [1:0] idx,
                                    input logic cin_l, input logic cy);
    logic ci;
    ci = 1'b0;
    case (opc)
      2'b10:   ci = (idx == 2'd0) ? cin_l : cy;
      2'b00:   ci = (idx == 2'd0) ? cin_l : ~cy;
      default: ci = 1'b0;
    endcase
    return ci;
  endfunction

  assign final_w = {alu_F, acc_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    alu_R   = 4'd0;
    alu_S   = 4'd0;
    alu_CI  = 1'b0;
    alu_I   = 2'd0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        alu_R  = nibble(r_q, cnt_q);
        alu_S  = nibble(s_q, cnt_q);
        alu_I  = op_q;
        alu_CI = chain_ci(op_q, cnt_q, cin_q, carry_q);
        if (cnt_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Partial nibbles collect in acc_q so the visible result only moves at completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 2'd0;
      op_q     <= 2'd0;
      s_q      <= 16'd0;
      r_q      <= 16'd0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      acc_q    <= 12'd0;
      result_q <= 16'd0;
      co_q     <= 1'b0;
      vo_q     <= 1'b0;
      no_q     <= 1'b0;
      zo_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            s_q   <= s;
            r_q   <= r;
            cin_q <= cin;
            cnt_q <= 2'd0;
          end
        end
        RUN: begin
          carry_q <= alu_CO;
          cnt_q   <= cnt_q + 2'd1;
          case (cnt_q)
            2'd0: acc_q[3:0]  <= alu_F;
            2'd1: acc_q[7:4]  <= alu_F;
            2'd2: acc_q[11:8] <= alu_F;
            default: begin
              result_q <= final_w;
              co_q     <= alu_CO;
              vo_q     <= alu_VO;
              no_q     <= alu_F[3];
              zo_q     <= ~|final_w;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign co     = co_q;
  assign vo     = vo_q;
  assign no     = no_q;
  assign zo     = zo_q;

endmodule

// File: tb/tb_alu16_sequencer.sv
// Bench for alu16_sequencer: behavioural 4-bit slice, directed vector table,
// multi-cycle corner sequences and randomized ops against a 16-bit arithmetic model.
module tb_alu16_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [1:0]  op;
  logic [15:0] s, r;
  logic [3:0]  alu_R, alu_S, alu_F;
  logic        alu_CI, alu_CO, alu_VO;
  logic [1:0]  alu_I;
  logic        busy, done, co, vo, no, zo;
  logic [15:0] result;

  int n_pass  = 0;
  int n_total = 0;

  alu16_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .s(s), .r(r), .cin(cin),
    .alu_R(alu_R), .alu_S(alu_S), .alu_CI(alu_CI), .alu_I(alu_I),
    .alu_F(alu_F), .alu_CO(alu_CO), .alu_VO(alu_VO),
    .busy(busy), .done(done), .result(result),
    .co(co), .vo(vo), .no(no), .zo(zo)
  );

  always #5 clk = ~clk;

  // 4-bit slice: 00 S-R-1+CI (CO = borrow), 01 S|R, 10 S+R+CI, 11 XNOR.
  int sl_t, sl_sv;
  always_comb begin
    sl_t   = 0;
    sl_sv  = 0;
    alu_F  = 4'd0;
    alu_CO = 1'b0;
    alu_VO = 1'b0;
    case (alu_I)
      2'b00: begin
        sl_t   = int'(alu_S) - int'(alu_R) - 1 + int'(alu_CI);
        sl_sv  = int'($signed(alu_S)) - int'($signed(alu_R)) - 1 + int'(alu_CI);
        alu_F  = sl_t[3:0];
        alu_CO = (sl_t < 0);
        alu_VO = (sl_sv > 7) || (sl_sv < -8);
      end
      2'b10: begin
        sl_t   = int'(alu_S) + int'(alu_R) + int'(alu_CI);
        sl_sv  = int'($signed(alu_S)) + int'($signed(alu_R)) + int'(alu_CI);
        alu_F  = sl_t[3:0];
        alu_CO = (sl_t > 15);
        alu_VO = (sl_sv > 7) || (sl_sv < -8);
      end
      2'b01:   alu_F = alu_S | alu_R;
      default: alu_F = ~(alu_S ^ alu_R);
    endcase
  end

  // Whole-word reference; flags packed as {co, vo, no, zo}.
  function automatic void ref_op(input logic [1:0] o, input logic [15:0] a, b, input logic c,
                                 output logic [15:0] res, output logic [3:0] fl);
    int t, st;
    logic cf, vf;
    t = 0; st = 0; cf = 1'b0; vf = 1'b0;
    case (o)
      2'b00: begin
        t   = int'(a) - int'(b) - 1 + int'(c);
        st  = int'($signed(a)) - int'($signed(b)) - 1 + int'(c);
        res = t[15:0];
        cf  = (t < 0);
        vf  = (st > 32767) || (st < -32768);
      end
      2'b10: begin
        t   = int'(a) + int'(b) + int'(c);
        st  = int'($signed(a)) + int'($signed(b)) + int'(c);
        res = t[15:0];
        cf  = (t > 65535);
        vf  = (st > 32767) || (st < -32768);
      end
      2'b01:   res = a | b;
      default: res = ~(a ^ b);
    endcase
    fl = {cf, vf, res[15], (res == 16'd0)};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  // One start pulse, then eight observed cycles; the block ends back in IDLE.
  task automatic run_op(input logic [1:0] o, input logic [15:0] a, b, input logic c,
                        output logic [15:0] res, output logic [3:0] fl, output logic [3:0] ci,
                        output int lat_ok, output int slice_err);
    int nb, nd, da;
    @(negedge clk);
    op = o; s = a; r = b; cin = c; start = 1'b1;
    @(posedge clk);
    nb = 0; nd = 0; da = -1; slice_err = 0; res = '0; fl = '0; ci = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) begin
        if (nb < 4) begin
          ci[nb] = alu_CI;
          if (alu_S !== a[4*nb +: 4] || alu_R !== b[4*nb +: 4] || alu_I !== o) slice_err++;
        end
        nb++;
      end else if (alu_S !== 4'd0 || alu_R !== 4'd0 || alu_I !== 2'd0 || alu_CI !== 1'b0) begin
        slice_err++;
      end
      if (done) begin
        nd++;
        if (da < 0) da = k;
        res = result;
        fl  = {co, vo, no, zo};
      end
    end
    lat_ok = (nb == 4 && nd == 1 && da == 4) ? 1 : 0;
  endtask

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] s;
    logic [15:0] r;
    logic        cin;
    logic [15:0] res;
    logic [3:0]  fl;
    logic [3:0]  ci;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [15:0] g_res, e_res;
    logic [3:0]  g_fl, e_fl, g_ci;
    int          lat, serr, nb, nd, ni;
    logic [1:0]  ro;
    logic [15:0] ra, rb;
    logic        rc;

    tbl[0] = '{2'b10, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 4'b0000, 4'b0110};
    tbl[1] = '{2'b00, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 4'b1010, 4'b0001};
    tbl[2] = '{2'b00, 16'h1234, 16'h1234, 1'b1, 16'h0000, 4'b0001, 4'b1111};
    tbl[3] = '{2'b11, 16'h1234, 16'h1234, 1'b0, 16'hFFFF, 4'b0010, 4'b0000};
    tbl[4] = '{2'b01, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'b0001, 4'b0000};
    tbl[5] = '{2'b10, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1001, 4'b1110};
    tbl[6] = '{2'b10, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0110, 4'b1110};
    tbl[7] = '{2'b00, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b0100, 4'b0001};
    tbl[8] = '{2'b01, 16'h00F0, 16'h0F00, 1'b1, 16'h0FF0, 4'b0000, 4'b0000};
    tbl[9] = '{2'b11, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 4'b0001, 4'b0000};

    rst = 1'b1; start = 1'b0; op = 2'd0; s = 16'd0; r = 16'd0; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result", result, 16'd0);
    check("reset_flags", {co, vo, no, zo}, 4'd0);
    check("reset_busy_done", {busy, done}, 2'd0);
    check("reset_slice_out", {alu_R, alu_S, alu_CI, alu_I}, 11'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].s, tbl[i].r, tbl[i].cin, g_res, g_fl, g_ci, lat, serr);
      check($sformatf("vec%0d_result", i), g_res, tbl[i].res);
      check($sformatf("vec%0d_flags", i), g_fl, tbl[i].fl);
      check($sformatf("vec%0d_ci_seq", i), g_ci, tbl[i].ci);
      check($sformatf("vec%0d_latency", i), lat, 1);
      check($sformatf("vec%0d_slice_in", i), serr, 0);
    end

    // start held high: one op per acceptance, with an IDLE cycle between ops.
    @(negedge clk);
    op = 2'b10; s = 16'h0ABC; r = 16'h1111; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    nb = 0; nd = 0; ni = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) nd++;
      if (!busy && !done) ni++;
      if (k == 11) start = 1'b0;
    end
    check("held_busy_cycles", nb, 8);
    check("held_done_pulses", nd, 2);
    check("held_idle_cycles", ni, 2);
    check("held_result", result, 16'h1BCE);

    // start pulsed mid-RUN with different operands must be ignored.
    @(negedge clk);
    op = 2'b00; s = 16'h5000; r = 16'h0123; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 2'b01; s = 16'hFFFF; r = 16'hAAAA; cin = 1'b0;
    nd = 0; g_res = '0; g_fl = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        nd++;
        g_res = result;
        g_fl  = {co, vo, no, zo};
      end
    end
    check("pulse_done_pulses", nd, 1);
    check("pulse_result", g_res, 16'h4EDD);
    check("pulse_flags", g_fl, 4'b0000);

    // Reset in the second RUN cycle aborts the operation.
    @(negedge clk);
    op = 2'b10; s = 16'h1234; r = 16'h1111; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_done", {busy, done}, 2'd0);
    check("abort_result", result, 16'd0);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);
    run_op(2'b10, 16'h1111, 16'h2222, 1'b0, g_res, g_fl, g_ci, lat, serr);
    check("after_abort_result", g_res, 16'h3333);
    check("after_abort_latency", lat, 1);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rc = 1'($urandom_range(0, 1));
      ref_op(ro, ra, rb, rc, e_res, e_fl);
      run_op(ro, ra, rb, rc, g_res, g_fl, g_ci, lat, serr);
      check($sformatf("rnd%0d_result", i), g_res, e_res);
      check($sformatf("rnd%0d_flags", i), g_fl, e_fl);
      check($sformatf("rnd%0d_latency", i), lat, 1);
      check($sformatf("rnd%0d_slice_in", i), serr, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
